// File: rtl/tx_frame_arbiter.sv
// Arbitrates register-read bytes and ALU results onto the single TX FIFO write port.
// Each frame (optional header, then payload LSB first) is written atomically under FIFO_FULL backpressure.
module tx_frame_arbiter #(
   parameter int unsigned           DATA_WIDTH = 8,
   parameter bit                    PRIO_MODE  = 1'b0,
   parameter bit                    HEADER_EN  = 1'b0,
   parameter logic [DATA_WIDTH-1:0] REG_HDR    = 8'h5A,
   parameter logic [DATA_WIDTH-1:0] ALU_HDR    = 8'hA5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    reg_req,
   input  logic [DATA_WIDTH-1:0]   reg_data,
   output logic                    reg_gnt,
   input  logic                    alu_req,
   input  logic [2*DATA_WIDTH-1:0] alu_data,
   output logic                    alu_gnt,
   input  logic                    FIFO_FULL,
   output logic [DATA_WIDTH-1:0]   WR_DATA,
   output logic                    WR_INC,
   output logic                    busy,
   output logic [7:0]              frame_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HDR   = 2'd1,
      S_BYTE0 = 2'd2,
      S_BYTE1 = 2'd3
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [2*DATA_WIDTH-1:0] payload;
   logic                    src_alu;
   logic                    rr_alu_last;
   logic                    grant;
   logic                    pick_alu;
   logic                    last_byte;

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      pick_alu  = 1'b0;
      reg_gnt   = 1'b0;
      alu_gnt   = 1'b0;
      WR_INC    = 1'b0;
      WR_DATA   = '0;
      last_byte = 1'b0;
      case (state)
         S_IDLE: begin
            // Grants are suppressed while reset is held so no pulse escapes without a capture.
            if (!rst && (reg_req || alu_req)) begin
               grant     = 1'b1;
               pick_alu  = PRIO_MODE ? alu_req : (alu_req && (!reg_req || !rr_alu_last));
               alu_gnt   = pick_alu;
               reg_gnt   = !pick_alu;
               state_nxt = HEADER_EN ? S_HDR : S_BYTE0;
            end
         end
         S_HDR: begin
            WR_INC  = !FIFO_FULL;
            WR_DATA = src_alu ? ALU_HDR : REG_HDR;
            if (WR_INC) state_nxt = S_BYTE0;
         end
         S_BYTE0: begin
            WR_INC  = !FIFO_FULL;
            WR_DATA = payload[DATA_WIDTH-1:0];
            if (WR_INC) begin
               if (src_alu) begin
                  state_nxt = S_BYTE1;
               end else begin
                  state_nxt = S_IDLE;
                  last_byte = 1'b1;
               end
            end
         end
         S_BYTE1: begin
            WR_INC  = !FIFO_FULL;
            WR_DATA = payload[2*DATA_WIDTH-1:DATA_WIDTH];
            if (WR_INC) begin
               state_nxt = S_IDLE;
               last_byte = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         payload     <= '0;
         src_alu     <= 1'b0;
         rr_alu_last <= 1'b1;
         frame_cnt   <= 8'd0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            src_alu     <= pick_alu;
            rr_alu_last <= pick_alu;
            payload     <= pick_alu ? alu_data : {{DATA_WIDTH{1'b0}}, reg_data};
         end
         if (last_byte) frame_cnt <= frame_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Directed bench for tx_frame_arbiter: round-robin, fixed-priority and header-enabled instances.
// Inputs are driven 1 time unit after the rising edge and outputs checked 2 units after it.
module tb_tx_frame_arbiter;

   logic        clk;
   logic        rst;
   logic        reg_req;
   logic [7:0]  reg_data;
   logic        alu_req;
   logic [15:0] alu_data;
   logic        fifo_full;

   logic        a_reg_gnt, a_alu_gnt, a_wr_inc, a_busy;
   logic [7:0]  a_wr_data, a_frame_cnt;
   logic        b_reg_gnt, b_alu_gnt, b_wr_inc, b_busy;
   logic [7:0]  b_wr_data, b_frame_cnt;
   logic        c_reg_gnt, c_alu_gnt, c_wr_inc, c_busy;
   logic [7:0]  c_wr_data, c_frame_cnt;

   int n_vec = 0;
   int n_err = 0;
   int n0;

   logic [7:0] a_log[$];
   logic [7:0] c_log[$];

   tx_frame_arbiter #(.DATA_WIDTH(8), .PRIO_MODE(1'b0), .HEADER_EN(1'b0)) dut_a (
      .clk(clk), .rst(rst),
      .reg_req(reg_req), .reg_data(reg_data), .reg_gnt(a_reg_gnt),
      .alu_req(alu_req), .alu_data(alu_data), .alu_gnt(a_alu_gnt),
      .FIFO_FULL(fifo_full), .WR_DATA(a_wr_data), .WR_INC(a_wr_inc),
      .busy(a_busy), .frame_cnt(a_frame_cnt)
   );

   tx_frame_arbiter #(.DATA_WIDTH(8), .PRIO_MODE(1'b1), .HEADER_EN(1'b0)) dut_b (
      .clk(clk), .rst(rst),
      .reg_req(reg_req), .reg_data(reg_data), .reg_gnt(b_reg_gnt),
      .alu_req(alu_req), .alu_data(alu_data), .alu_gnt(b_alu_gnt),
      .FIFO_FULL(fifo_full), .WR_DATA(b_wr_data), .WR_INC(b_wr_inc),
      .busy(b_busy), .frame_cnt(b_frame_cnt)
   );

   tx_frame_arbiter #(.DATA_WIDTH(8), .PRIO_MODE(1'b0), .HEADER_EN(1'b1)) dut_c (
      .clk(clk), .rst(rst),
      .reg_req(reg_req), .reg_data(reg_data), .reg_gnt(c_reg_gnt),
      .alu_req(alu_req), .alu_data(alu_data), .alu_gnt(c_alu_gnt),
      .FIFO_FULL(fifo_full), .WR_DATA(c_wr_data), .WR_INC(c_wr_inc),
      .busy(c_busy), .frame_cnt(c_frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (a_wr_inc) a_log.push_back(a_wr_data);
      if (c_wr_inc) c_log.push_back(c_wr_data);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick();
      rst       = 1'b1;
      reg_req   = 1'b0;
      alu_req   = 1'b0;
      fifo_full = 1'b0;
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      reg_req   = 1'b0;
      reg_data  = 8'h00;
      alu_req   = 1'b0;
      alu_data  = 16'h0000;
      fifo_full = 1'b0;

      // Reset state, and no grant escapes while reset is held.
      #2;
      check("rst_wr_inc", a_wr_inc, 0);
      check("rst_wr_data", a_wr_data, 0);
      check("rst_busy", a_busy, 0);
      check("rst_frame_cnt", a_frame_cnt, 0);
      reg_req = 1'b1;
      #1;
      check("rst_no_gnt", a_reg_gnt, 0);
      reg_req = 1'b0;
      rst     = 1'b0;

      // Single register-read frame.
      tick();
      reg_req  = 1'b1;
      reg_data = 8'h3C;
      #1;
      check("t1_reg_gnt", a_reg_gnt, 1);
      check("t1_alu_gnt", a_alu_gnt, 0);
      check("t1_idle_inc", a_wr_inc, 0);
      tick();
      reg_req  = 1'b0;
      reg_data = 8'hFF;
      #1;
      check("t1_wr_inc", a_wr_inc, 1);
      check("t1_wr_data", a_wr_data, 8'h3C);
      check("t1_busy", a_busy, 1);
      check("t1_gnt_pulse", a_reg_gnt, 0);
      tick();
      check("t1_idle_busy", a_busy, 0);
      check("t1_idle_data", a_wr_data, 0);
      check("t1_frame_cnt", a_frame_cnt, 1);

      // ALU frame, LSB first; input changed after grant must not leak in.
      alu_req  = 1'b1;
      alu_data = 16'hBEEF;
      #1;
      check("t2_alu_gnt", a_alu_gnt, 1);
      tick();
      alu_req  = 1'b0;
      alu_data = 16'h0000;
      #1;
      check("t2_b0_inc", a_wr_inc, 1);
      check("t2_b0_data", a_wr_data, 8'hEF);
      tick();
      check("t2_b1_inc", a_wr_inc, 1);
      check("t2_b1_data", a_wr_data, 8'hBE);
      tick();
      check("t2_busy", a_busy, 0);
      check("t2_frame_cnt", a_frame_cnt, 2);

      // Simultaneous requests: round-robin alternates, fixed priority favours ALU.
      do_reset();
      reg_req  = 1'b1;
      reg_data = 8'h01;
      alu_req  = 1'b1;
      alu_data = 16'h0302;
      #1;
      check("t3_rr_first_reg", a_reg_gnt, 1);
      check("t3_rr_first_alu", a_alu_gnt, 0);
      check("t3_prio_alu", b_alu_gnt, 1);
      check("t3_prio_reg", b_reg_gnt, 0);
      tick();
      reg_req = 1'b0;
      #1;
      check("t3_reg_byte", a_wr_data, 8'h01);
      check("t3_wait_busy", a_alu_gnt, 0);
      tick();
      reg_req  = 1'b1;
      reg_data = 8'h04;
      #1;
      check("t3_rr_second_alu", a_alu_gnt, 1);
      check("t3_rr_second_reg", a_reg_gnt, 0);
      tick();
      alu_req = 1'b0;
      #1;
      check("t3_alu_b0", a_wr_data, 8'h02);
      tick();
      check("t3_alu_b1", a_wr_data, 8'h03);
      tick();
      alu_req = 1'b1;
      #1;
      check("t3_rr_third_reg", a_reg_gnt, 1);
      check("t3_rr_third_alu", a_alu_gnt, 0);

      // FIFO full for five cycles during BYTE1.
      do_reset();
      n0       = a_log.size();
      alu_req  = 1'b1;
      alu_data = 16'hBEEF;
      #1;
      check("t4_gnt", a_alu_gnt, 1);
      tick();
      alu_req = 1'b0;
      #1;
      check("t4_b0_data", a_wr_data, 8'hEF);
      tick();
      fifo_full = 1'b1;
      #1;
      check("t4_full_inc", a_wr_inc, 0);
      check("t4_full_data", a_wr_data, 8'hBE);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t4_hold_inc", a_wr_inc, 0);
         check("t4_hold_data", a_wr_data, 8'hBE);
         check("t4_hold_busy", a_busy, 1);
      end
      tick();
      fifo_full = 1'b0;
      #1;
      check("t4_resume_inc", a_wr_inc, 1);
      check("t4_resume_data", a_wr_data, 8'hBE);
      tick();
      check("t4_done_busy", a_busy, 0);
      check("t4_frame_cnt", a_frame_cnt, 1);
      check("t4_byte_count", a_log.size() - n0, 2);
      check("t4_log0", a_log[n0], 8'hEF);
      check("t4_log1", a_log[n0+1], 8'hBE);

      // Header-enabled frames.
      do_reset();
      n0       = c_log.size();
      reg_req  = 1'b1;
      reg_data = 8'h11;
      #1;
      check("t5_reg_gnt", c_reg_gnt, 1);
      tick();
      reg_req = 1'b0;
      #1;
      check("t5_reg_hdr_inc", c_wr_inc, 1);
      check("t5_reg_hdr", c_wr_data, 8'h5A);
      tick();
      check("t5_reg_byte", c_wr_data, 8'h11);
      tick();
      alu_req  = 1'b1;
      alu_data = 16'h1234;
      #1;
      check("t5_alu_gnt", c_alu_gnt, 1);
      tick();
      alu_req = 1'b0;
      #1;
      check("t5_alu_hdr", c_wr_data, 8'hA5);
      tick();
      check("t5_alu_b0", c_wr_data, 8'h34);
      tick();
      check("t5_alu_b1", c_wr_data, 8'h12);
      tick();
      check("t5_busy", c_busy, 0);
      check("t5_frame_cnt", c_frame_cnt, 2);
      check("t5_byte_count", c_log.size() - n0, 5);
      check("t5_log_hdr", c_log[n0+2], 8'hA5);

      // Reset mid-frame, then a normal frame.
      do_reset();
      reg_req  = 1'b1;
      reg_data = 8'h77;
      tick();
      reg_req = 1'b0;
      tick();
      check("t6_pre_cnt", a_frame_cnt, 1);
      alu_req  = 1'b1;
      alu_data = 16'hBEEF;
      tick();
      alu_req = 1'b0;
      #1;
      check("t6_mid_busy", a_busy, 1);
      check("t6_mid_data", a_wr_data, 8'hEF);
      rst = 1'b1;
      #1;
      check("t6_rst_inc", a_wr_inc, 0);
      check("t6_rst_data", a_wr_data, 0);
      check("t6_rst_busy", a_busy, 0);
      check("t6_rst_cnt", a_frame_cnt, 0);
      rst = 1'b0;
      tick();
      check("t6_after_idle", a_busy, 0);
      reg_req  = 1'b1;
      reg_data = 8'h3C;
      #1;
      check("t6_new_gnt", a_reg_gnt, 1);
      tick();
      reg_req = 1'b0;
      #1;
      check("t6_new_data", a_wr_data, 8'h3C);
      tick();
      check("t6_new_cnt", a_frame_cnt, 1);

      // frame_cnt wraps after 256 frames.
      do_reset();
      for (int i = 0; i < 255; i++) begin
         reg_req  = 1'b1;
         reg_data = 8'(i);
         tick();
         reg_req = 1'b0;
         tick();
      end
      check("t6_cnt_255", a_frame_cnt, 255);
      reg_req = 1'b1;
      tick();
      reg_req = 1'b0;
      tick();
      check("t6_cnt_wrap", a_frame_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
